// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter: load/store codes, FSM state
// encoding and small helpers for byte counts and load extension.
package mem_pkg;

  localparam logic [3:0] MT_NONE = 4'd0;
  localparam logic [3:0] MT_LB   = 4'd1;
  localparam logic [3:0] MT_LH   = 4'd2;
  localparam logic [3:0] MT_LW   = 4'd3;
  localparam logic [3:0] MT_LBU  = 4'd4;
  localparam logic [3:0] MT_LHU  = 4'd5;
  localparam logic [3:0] MT_SB   = 4'd6;
  localparam logic [3:0] MT_SH   = 4'd7;
  localparam logic [3:0] MT_SW   = 4'd8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Zero marks an unknown code, which the arbiter treats as no request.
  function automatic logic [2:0] byte_count(input logic [3:0] mtype);
    case (mtype)
      MT_LB, MT_LBU, MT_SB: byte_count = 3'd1;
      MT_LH, MT_LHU, MT_SH: byte_count = 3'd2;
      MT_LW, MT_SW:         byte_count = 3'd4;
      default:              byte_count = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] mtype);
    is_store = (mtype == MT_SB) || (mtype == MT_SH) || (mtype == MT_SW);
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] mtype,
                                              input logic [31:0] word);
    case (mtype)
      MT_LB:   load_extend = {{24{word[7]}}, word[7:0]};
      MT_LBU:  load_extend = {24'h000000, word[7:0]};
      MT_LH:   load_extend = {{16{word[15]}}, word[15:0]};
      MT_LHU:  load_extend = {16'h0000, word[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Combinational sign/zero extension of an assembled little-endian load word.
module mem_extend
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      mem_type,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = word;
    case (mem_type)
      MT_LB:   ext = {{(XLEN-8){word[7]}}, word[7:0]};
      MT_LBU:  ext = {{(XLEN-8){1'b0}}, word[7:0]};
      MT_LH:   ext = {{(XLEN-16){word[15]}}, word[15:0]};
      MT_LHU:  ext = {{(XLEN-16){1'b0}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and the MEM stage,
// serialising each access into byte cycles with registered RAM outputs.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [XLEN-1:0]   if_inst,
  input  logic              mem_req,
  input  logic [3:0]        mem_type,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              mem_done,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  logic [2:0]        state;
  logic              owner_if;
  logic [3:0]        cur_type;
  logic [ADDR_W-1:0] base_addr;
  logic [XLEN-1:0]   wdata_q;
  logic [1:0]        cnt;
  logic [1:0]        last_idx;
  logic [XLEN-1:0]   asm_word;

  logic [2:0]        mem_cnt;
  logic              mem_valid;
  logic              if_grant;
  logic [1:0]        mem_last;
  logic [1:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              abort_if;
  logic [1:0]        rx_idx;
  logic [XLEN-1:0]   rx_word;
  logic [XLEN-1:0]   ext_word;

  assign busy      = (state != ST_IDLE);
  assign mem_cnt   = byte_count(mem_type);
  assign mem_valid = mem_req && (mem_cnt != 3'd0);
  assign if_grant  = !mem_valid && if_req && !if_flush;
  assign mem_last  = mem_cnt[1:0] - 2'd1;
  assign cnt_nxt   = cnt + 2'd1;
  assign addr_nxt  = base_addr + ADDR_W'(cnt_nxt);
  assign abort_if  = owner_if && if_flush;

  // The byte on ram_din belongs to the address issued one cycle earlier;
  // in WAIT that is the final byte of the access.
  always_comb begin
    rx_idx  = (state == ST_WAIT) ? last_idx : (cnt - 2'd1);
    rx_word = asm_word;
    rx_word[{rx_idx, 3'b000} +: 8] = ram_din;
  end

  mem_extend #(.XLEN(XLEN)) u_extend (
    .mem_type (cur_type),
    .word     (rx_word),
    .ext      (ext_word)
  );

  // Single FSM owns the RAM port; done pulses and RAM strobes are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner_if  <= 1'b0;
      cur_type  <= MT_NONE;
      base_addr <= '0;
      wdata_q   <= '0;
      cnt       <= 2'd0;
      last_idx  <= 2'd0;
      asm_word  <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_inst   <= '0;
      mem_rdata <= '0;
      ram_a     <= '0;
      ram_dout  <= 8'h00;
      ram_wr    <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt      <= 2'd0;
          asm_word <= '0;
          if (mem_valid) begin
            owner_if  <= 1'b0;
            cur_type  <= mem_type;
            base_addr <= mem_addr;
            wdata_q   <= mem_wdata;
            last_idx  <= mem_last;
            ram_a     <= mem_addr;
            if (is_store(mem_type)) begin
              ram_dout <= mem_wdata[7:0];
              ram_wr   <= 1'b1;
              state    <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end else if (if_grant) begin
            owner_if  <= 1'b1;
            cur_type  <= MT_LW;
            base_addr <= if_addr;
            last_idx  <= 2'd3;
            ram_a     <= if_addr;
            state     <= ST_READ;
          end
        end

        ST_READ: begin
          if (abort_if) begin
            ram_a <= '0;
            state <= ST_IDLE;
          end else begin
            if (cnt != 2'd0) begin
              asm_word <= rx_word;
            end
            if (cnt == last_idx) begin
              ram_a <= '0;
              state <= ST_WAIT;
            end else begin
              cnt   <= cnt_nxt;
              ram_a <= addr_nxt;
            end
          end
        end

        ST_WAIT: begin
          if (abort_if) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_DONE;
            if (owner_if) begin
              if_done <= 1'b1;
              if_inst <= ext_word;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= ext_word;
            end
          end
        end

        ST_WRITE: begin
          if (cnt == last_idx) begin
            ram_a    <= '0;
            ram_dout <= 8'h00;
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt      <= cnt_nxt;
            ram_a    <= addr_nxt;
            ram_dout <= wdata_q[{cnt_nxt, 3'b000} +: 8];
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single byte-wide RAM port between two requesters: instruction fetch (IF, word reads only) and the MEM stage (loads and stores driven by EX's load/store type, address and store data).
- Serialises each access into byte transactions, assembles and extends load results, and returns a one-cycle done pulse per requester.
- Sits between if and mem stages and the RAM. Stall control consumes the busy/done outputs.

Parameters:
- ADDR_W, 32, byte address width.
- XLEN, 32, register/data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address (word-aligned by caller)
- if_flush  in  1  abort pending or in-flight fetch (taken branch/jump)
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  XLEN  fetched word, little-endian
- mem_req  in  1  data request, held until mem_done
- mem_type  in  4  load/store code (package constants)
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  XLEN  store data, low bytes used
- mem_done  out  1  one-cycle pulse
- mem_rdata  out  XLEN  extended load result, valid with mem_done
- busy  out  1  high in any non-IDLE state
- ram_a  out  ADDR_W  RAM byte address (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_wr  out  1  RAM write strobe (registered)
- ram_din  in  8  RAM read byte, valid one cycle after ram_a

Behaviour:
- Reset: at the edge with rst=1, state goes to IDLE. if_done, mem_done, ram_wr and busy go to 0; ram_a, ram_dout, if_inst and mem_rdata go to 0. This applies mid-transfer too: the partial access is dropped and no done is issued.
- mem_type codes: LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8. Byte count N is 1 for B, 2 for H, 4 for W. Code 0 or any other code is treated as no request.
- States:
  - IDLE: waiting for a request.
  - READ: N address cycles.
  - WAIT: last byte in flight.
  - WRITE: N byte cycles.
  - DONE: one cycle; the pulse cycle.
- Arbitration in IDLE: mem_req has priority over if_req. A transfer in progress is never preempted. A requester's req is ignored in the cycle its done is high, so the held req is not re-granted.
- Grant in cycle T is captured at the edge ending T.
- Read, byte k = 0..N-1:
  - ram_a = addr+k during cycle T+1+k, with ram_wr=0.
  - Byte k is sampled from ram_din at the edge ending T+2+k.
  - The done pulse and data are valid in cycle T+N+2.
  - Word latency: grant to done is 6 cycles. Byte latency: 3 cycles.
- Write, byte k:
  - ram_a = addr+k, ram_dout = mem_wdata[8k+7:8k], ram_wr=1 during cycle T+1+k.
  - mem_done is high in cycle T+N+1.
  - ram_wr is 0 in the done cycle.
- Assembly is little-endian: byte k goes to bits [8k+7:8k].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW is taken as is.
- Address arithmetic is modulo 2^ADDR_W; addr+k wraps from 0xFFFFFFFF to 0.
- Unaligned halfword/word addresses are legal and simply access consecutive bytes.
- if_flush:
  - In IDLE, a same-cycle if_req is not granted.
  - During an IF transfer, the transfer ends at that edge: return to IDLE, no if_done, ram_wr stays 0.
  - Has no effect on MEM transfers.
- Outside active transfers: ram_a=0, ram_wr=0, ram_dout=0.
- if_inst and mem_rdata hold their last value between dones.

Decomposition:
- Package mem_pkg holds:
  - the mem_type codes;
  - state encoding (IDLE, READ, WAIT, WRITE, DONE);
  - a byte-count function and a load-extend function.
- Sub-module mem_extend: combinational sign/zero extension of the assembled word by mem_type. The FSM, counter and byte assembly stay in mem_arbiter.

Test Plan:
- IF word read: RAM holds 0x13,0x05,0x10,0x00 at 0x100; if_req, if_addr=0x100 granted at T -> ram_a 0x100..0x103 in T+1..T+4; if_done in T+6 with if_inst=0x00100513.
- Load extend: byte 0x80 at 0x20 -> LB returns 0xFFFFFF80 after 3 cycles, LBU returns 0x00000080. Halfword 0x8001 -> LH returns 0xFFFF8001.
- SH store: mem_addr=0x40, wdata=0xDEADBEEF -> ram_wr=1 with (0x40,0xEF), (0x41,0xBE) in consecutive cycles; mem_done next cycle, ram_wr=0.
- Arbitration: if_req and mem_req (LW) in the same IDLE cycle -> MEM served first. IF is granted the cycle after mem_done and completes 6 cycles later. Also, mem_req raised mid-fetch waits for if_done.
- Flush and wrap: if_flush at cycle T+2 of a fetch -> no if_done, IDLE next cycle. LW at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-SW: rst=1 during the second byte -> ram_wr=0, busy=0 next cycle, no mem_done; fresh requests are served normally afterwards.
